hdmi_timing_engine: RTL and testbench

- Parametrised, run-time-reconfigurable successor to the fixed 1024x600 video timing generator.
- Produces active, polarity-programmable h/v sync, line/frame start strobes and pixel coordinates for the TMDS encoder path.
- New timings load over a valid/ready handshake into a shadow set and take effect only at a frame boundary, so a mode change never produces a torn frame.

---
 rtl/hdmi_timing_pkg.sv | 33 +++
 rtl/timing_axis.sv | 54 +++++
 rtl/hdmi_timing_engine.sv | 199 +++++++++++++++++++
 tb/tb_hdmi_timing_engine.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_timing_pkg.sv
// Shared constants for the HDMI timing engine: packed-field layout, reset
// defaults, polarity bit positions and the common logic levels.
package hdmi_timing_pkg;

    // Field order inside cfg_h / cfg_v, active in the LSBs.
    localparam int unsigned FIELD_ACTIVE = 0;
    localparam int unsigned FIELD_FRONT  = 1;
    localparam int unsigned FIELD_SYNC   = 2;
    localparam int unsigned FIELD_BACK   = 3;

    localparam int unsigned POL_H = 0;
    localparam int unsigned POL_V = 1;

    localparam logic YES = 1'b1;
    localparam logic NO  = 1'b0;
    localparam logic LOW = 1'b0;

    localparam int unsigned DEF_H_ACTIVE = 1024;
    localparam int unsigned DEF_H_FRONT  = 48;
    localparam int unsigned DEF_H_SYNC   = 32;
    localparam int unsigned DEF_H_BACK   = 266;
    localparam int unsigned DEF_V_ACTIVE = 600;
    localparam int unsigned DEF_V_FRONT  = 3;
    localparam int unsigned DEF_V_SYNC   = 6;
    localparam int unsigned DEF_V_BACK   = 21;
    localparam logic [1:0]  DEF_POL      = 2'b11;

    // Drive level of a sync pin: pol = 1 means active-high.
    function automatic logic sync_level(input logic in_sync, input logic pol);
        return in_sync ^ ~pol;
    endfunction

endpackage

// File: rtl/timing_axis.sv
// One axis of the raster: a wrapping position counter plus active/sync region
// decode against the four live field lengths.
module timing_axis import hdmi_timing_pkg::*; #(
    parameter int unsigned BITS = 12
) (
    input  logic            clk,
    input  logic            reset_low,
    input  logic            advance,
    input  logic [BITS-1:0] active_len,
    input  logic [BITS-1:0] front_len,
    input  logic [BITS-1:0] sync_len,
    input  logic [BITS-1:0] back_len,
    output logic [BITS-1:0] index,
    output logic            in_active,
    output logic            in_sync,
    output logic            at_last
);

    // Two guard bits so the sum of four fields can never overflow.
    localparam int unsigned W = BITS + 2;

    logic [W-1:0]    index_w;
    logic [W-1:0]    sync_start;
    logic [W-1:0]    sync_end;
    logic [W-1:0]    total;
    logic [BITS-1:0] index_q, index_d;

    assign index_w    = W'(index_q);
    assign sync_start = W'(active_len) + W'(front_len);
    assign sync_end   = sync_start + W'(sync_len);
    assign total      = sync_end + W'(back_len);

    assign in_active = index_w < W'(active_len);
    assign in_sync   = (index_w >= sync_start) && (index_w < sync_end);
    assign at_last   = index_w == (total - W'(1));

    always_comb begin
        index_d = index_q;
        if (advance) begin
            index_d = at_last ? '0 : index_q + BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_low) begin
        if (reset_low == LOW) begin
            index_q <= '0;
        end else begin
            index_q <= index_d;
        end
    end

    assign index = index_q;

endmodule

// File: rtl/hdmi_timing_engine.sv
// Run-time reconfigurable video timing generator. New timings are validated on
// offer, held in a shadow set and swapped in only at the last pixel of a frame.
module hdmi_timing_engine import hdmi_timing_pkg::*; #(
    parameter int unsigned H_BITS       = 12,
    parameter int unsigned V_BITS       = 11,
    parameter int unsigned H_ACTIVE_DEF = DEF_H_ACTIVE,
    parameter int unsigned H_FRONT_DEF  = DEF_H_FRONT,
    parameter int unsigned H_SYNC_DEF   = DEF_H_SYNC,
    parameter int unsigned H_BACK_DEF   = DEF_H_BACK,
    parameter int unsigned V_ACTIVE_DEF = DEF_V_ACTIVE,
    parameter int unsigned V_FRONT_DEF  = DEF_V_FRONT,
    parameter int unsigned V_SYNC_DEF   = DEF_V_SYNC,
    parameter int unsigned V_BACK_DEF   = DEF_V_BACK,
    parameter logic [1:0]  POL_DEF      = DEF_POL
) (
    input  logic                clk,
    input  logic                reset_low,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [4*H_BITS-1:0] cfg_h,
    input  logic [4*V_BITS-1:0] cfg_v,
    input  logic [1:0]          cfg_pol,
    output logic                cfg_applied,
    output logic                cfg_error,
    output logic                active,
    output logic                h_sync,
    output logic                v_sync,
    output logic                h_start,
    output logic                v_start,
    output logic [H_BITS-1:0]   x,
    output logic [V_BITS-1:0]   y
);

    localparam int unsigned HW = H_BITS + 2;
    localparam int unsigned VW = V_BITS + 2;

    localparam logic [4*H_BITS-1:0] H_RESET = {H_BITS'(H_BACK_DEF), H_BITS'(H_SYNC_DEF),
                                               H_BITS'(H_FRONT_DEF), H_BITS'(H_ACTIVE_DEF)};
    localparam logic [4*V_BITS-1:0] V_RESET = {V_BITS'(V_BACK_DEF), V_BITS'(V_SYNC_DEF),
                                               V_BITS'(V_FRONT_DEF), V_BITS'(V_ACTIVE_DEF)};

    logic [4*H_BITS-1:0] live_h_q, live_h_d, pend_h_q, pend_h_d;
    logic [4*V_BITS-1:0] live_v_q, live_v_d, pend_v_q, pend_v_d;
    logic [1:0]          live_pol_q, live_pol_d, pend_pol_q, pend_pol_d;
    logic                pending_q, pending_d;

    logic                active_q, active_d, h_sync_q, h_sync_d, v_sync_q, v_sync_d;
    logic                h_start_q, h_start_d, v_start_q, v_start_d;
    logic                applied_q, applied_d, error_q, error_d;
    logic [H_BITS-1:0]   x_q, x_d;
    logic [V_BITS-1:0]   y_q, y_d;

    logic [H_BITS-1:0]   h_index;
    logic [V_BITS-1:0]   v_index;
    logic                h_act, h_syn, h_last, v_act, v_syn, v_last;
    logic                apply;
    logic [HW-1:0]       cfg_ht;
    logic [VW-1:0]       cfg_vt;
    logic                cfg_bad;

    timing_axis #(.BITS(H_BITS)) u_h_axis (
        .clk        (clk),
        .reset_low  (reset_low),
        .advance    (YES),
        .active_len (live_h_q[FIELD_ACTIVE*H_BITS +: H_BITS]),
        .front_len  (live_h_q[FIELD_FRONT*H_BITS +: H_BITS]),
        .sync_len   (live_h_q[FIELD_SYNC*H_BITS +: H_BITS]),
        .back_len   (live_h_q[FIELD_BACK*H_BITS +: H_BITS]),
        .index      (h_index),
        .in_active  (h_act),
        .in_sync    (h_syn),
        .at_last    (h_last)
    );

    timing_axis #(.BITS(V_BITS)) u_v_axis (
        .clk        (clk),
        .reset_low  (reset_low),
        .advance    (h_last),
        .active_len (live_v_q[FIELD_ACTIVE*V_BITS +: V_BITS]),
        .front_len  (live_v_q[FIELD_FRONT*V_BITS +: V_BITS]),
        .sync_len   (live_v_q[FIELD_SYNC*V_BITS +: V_BITS]),
        .back_len   (live_v_q[FIELD_BACK*V_BITS +: V_BITS]),
        .index      (v_index),
        .in_active  (v_act),
        .in_sync    (v_syn),
        .at_last    (v_last)
    );

    assign cfg_ht = HW'(cfg_h[FIELD_ACTIVE*H_BITS +: H_BITS]) +
                    HW'(cfg_h[FIELD_FRONT*H_BITS +: H_BITS]) +
                    HW'(cfg_h[FIELD_SYNC*H_BITS +: H_BITS]) +
                    HW'(cfg_h[FIELD_BACK*H_BITS +: H_BITS]);
    assign cfg_vt = VW'(cfg_v[FIELD_ACTIVE*V_BITS +: V_BITS]) +
                    VW'(cfg_v[FIELD_FRONT*V_BITS +: V_BITS]) +
                    VW'(cfg_v[FIELD_SYNC*V_BITS +: V_BITS]) +
                    VW'(cfg_v[FIELD_BACK*V_BITS +: V_BITS]);

    assign cfg_bad = (cfg_h[FIELD_ACTIVE*H_BITS +: H_BITS] == '0) ||
                     (cfg_h[FIELD_SYNC*H_BITS +: H_BITS] == '0) ||
                     (cfg_v[FIELD_ACTIVE*V_BITS +: V_BITS] == '0) ||
                     (cfg_v[FIELD_SYNC*V_BITS +: V_BITS] == '0) ||
                     (cfg_ht > (HW'(1) << H_BITS)) ||
                     (cfg_vt > (VW'(1) << V_BITS));

    // Counters wrap to 0 naturally on the last pixel, so applying here needs no counter reset.
    assign apply = pending_q && h_last && v_last;

    always_comb begin
        live_h_d   = live_h_q;
        live_v_d   = live_v_q;
        live_pol_d = live_pol_q;
        pend_h_d   = pend_h_q;
        pend_v_d   = pend_v_q;
        pend_pol_d = pend_pol_q;
        pending_d  = pending_q;
        error_d    = NO;
        applied_d  = NO;

        if (cfg_valid && !pending_q) begin
            if (cfg_bad) begin
                error_d = YES;
            end else begin
                pending_d  = YES;
                pend_h_d   = cfg_h;
                pend_v_d   = cfg_v;
                pend_pol_d = cfg_pol;
            end
        end

        if (apply) begin
            live_h_d   = pend_h_q;
            live_v_d   = pend_v_q;
            live_pol_d = pend_pol_q;
            pending_d  = NO;
            applied_d  = YES;
        end
    end

    // Sync pins use the post-apply polarity so it lands together with cfg_applied.
    always_comb begin
        active_d  = h_act && v_act;
        h_sync_d  = sync_level(h_syn, live_pol_d[POL_H]);
        v_sync_d  = sync_level(v_syn, live_pol_d[POL_V]);
        h_start_d = (h_index == '0) && v_act;
        v_start_d = h_start_d && (v_index == '0);
        x_d       = active_d ? h_index : x_q;
        y_d       = active_d ? v_index : y_q;
    end

    always_ff @(posedge clk or negedge reset_low) begin
        if (reset_low == LOW) begin
            live_h_q   <= H_RESET;
            live_v_q   <= V_RESET;
            live_pol_q <= POL_DEF;
            pend_h_q   <= '0;
            pend_v_q   <= '0;
            pend_pol_q <= '0;
            pending_q  <= NO;
            active_q   <= NO;
            h_sync_q   <= ~POL_DEF[POL_H];
            v_sync_q   <= ~POL_DEF[POL_V];
            h_start_q  <= NO;
            v_start_q  <= NO;
            applied_q  <= NO;
            error_q    <= NO;
            x_q        <= '0;
            y_q        <= '0;
        end else begin
            live_h_q   <= live_h_d;
            live_v_q   <= live_v_d;
            live_pol_q <= live_pol_d;
            pend_h_q   <= pend_h_d;
            pend_v_q   <= pend_v_d;
            pend_pol_q <= pend_pol_d;
            pending_q  <= pending_d;
            active_q   <= active_d;
            h_sync_q   <= h_sync_d;
            v_sync_q   <= v_sync_d;
            h_start_q  <= h_start_d;
            v_start_q  <= v_start_d;
            applied_q  <= applied_d;
            error_q    <= error_d;
            x_q        <= x_d;
            y_q        <= y_d;
        end
    end

    assign cfg_ready   = ~pending_q;
    assign cfg_applied = applied_q;
    assign cfg_error   = error_q;
    assign active      = active_q;
    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign h_start     = h_start_q;
    assign v_start     = v_start_q;
    assign x           = x_q;
    assign y           = y_q;

endmodule

// File: tb/tb_hdmi_timing_engine.sv
// Randomised bench for hdmi_timing_engine with a cycle-level raster model built
// from the field-length rules; the DUT uses small defaults to keep frames short.
module tb_hdmi_timing_engine;

    localparam int HB = 8;
    localparam int VB = 6;
    localparam int TIMEOUT = 5000;

    typedef struct {
        int a;
        int f;
        int s;
        int b;
    } axis_t;

    typedef struct {
        axis_t      h;
        axis_t      v;
        logic [1:0] pol;
    } cfg_t;

    logic            clk;
    logic            reset_low;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [4*HB-1:0] cfg_h;
    logic [4*VB-1:0] cfg_v;
    logic [1:0]      cfg_pol;
    logic            cfg_applied, cfg_error;
    logic            active, h_sync, v_sync, h_start, v_start;
    logic [HB-1:0]   x;
    logic [VB-1:0]   y;

    hdmi_timing_engine #(
        .H_BITS(HB), .V_BITS(VB),
        .H_ACTIVE_DEF(20), .H_FRONT_DEF(3), .H_SYNC_DEF(4), .H_BACK_DEF(5),
        .V_ACTIVE_DEF(10), .V_FRONT_DEF(2), .V_SYNC_DEF(3), .V_BACK_DEF(4),
        .POL_DEF(2'b11)
    ) dut (
        .clk(clk), .reset_low(reset_low), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_h(cfg_h), .cfg_v(cfg_v), .cfg_pol(cfg_pol), .cfg_applied(cfg_applied),
        .cfg_error(cfg_error), .active(active), .h_sync(h_sync), .v_sync(v_sync),
        .h_start(h_start), .v_start(v_start), .x(x), .y(y)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit chk_en = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pack(input bit act, input bit hs, input bit vs,
                                         input bit hst, input bit vst, input bit rdy,
                                         input bit app, input bit err, input int px,
                                         input int py);
        return {10'd0, act, hs, vs, hst, vst, rdy, app, err, HB'(px), VB'(py)};
    endfunction

    logic [31:0] obs;
    assign obs = {10'd0, active, h_sync, v_sync, h_start, v_start, cfg_ready, cfg_applied,
                  cfg_error, x, y};

    // ---------------- reference model ----------------
    cfg_t m_def, m_live, m_pcfg;
    bit   m_pend;
    int   m_h, m_v;
    bit   e_act, e_hs, e_vs, e_hst, e_vst, e_rdy, e_app, e_err;
    int   e_x, e_y;

    function automatic int tot(input axis_t t);
        return t.a + t.f + t.s + t.b;
    endfunction

    function automatic bit in_sync_region(input int i, input axis_t t);
        return (i >= t.a + t.f) && (i < t.a + t.f + t.s);
    endfunction

    function automatic bit is_bad(input cfg_t c);
        return c.h.a == 0 || c.h.s == 0 || c.v.a == 0 || c.v.s == 0 ||
               tot(c.h) > (1 << HB) || tot(c.v) > (1 << VB);
    endfunction

    task automatic m_reset();
        m_def.h = '{a: 20, f: 3, s: 4, b: 5};
        m_def.v = '{a: 10, f: 2, s: 3, b: 4};
        m_def.pol = 2'b11;
        m_live = m_def;
        m_pend = 0;
        m_h = 0;
        m_v = 0;
        e_act = 0; e_hs = 0; e_vs = 0; e_hst = 0; e_vst = 0;
        e_rdy = 1; e_app = 0; e_err = 0; e_x = 0; e_y = 0;
    endtask

    task automatic m_step();
        int ht, vt;
        bit hact, vact, hs, vs, do_apply, acc;
        logic [1:0] pol;
        cfg_t c;
        logic [4*HB-1:0] hbits;
        logic [4*VB-1:0] vbits;
        ht = tot(m_live.h);
        vt = tot(m_live.v);
        hact = m_h < m_live.h.a;
        vact = m_v < m_live.v.a;
        hs = in_sync_region(m_h, m_live.h);
        vs = in_sync_region(m_v, m_live.v);
        do_apply = m_pend && (m_h == ht - 1) && (m_v == vt - 1);
        acc = cfg_valid && !m_pend;
        pol = do_apply ? m_pcfg.pol : m_live.pol;
        e_act = hact && vact;
        e_hs = pol[0] ? hs : !hs;
        e_vs = pol[1] ? vs : !vs;
        e_hst = (m_h == 0) && vact;
        e_vst = e_hst && (m_v == 0);
        if (e_act) begin
            e_x = m_h;
            e_y = m_v;
        end
        e_app = do_apply;
        e_err = 0;
        if (acc) begin
            hbits = cfg_h;
            vbits = cfg_v;
            c.h = '{a: int'(hbits[0 +: HB]), f: int'(hbits[HB +: HB]),
                    s: int'(hbits[2*HB +: HB]), b: int'(hbits[3*HB +: HB])};
            c.v = '{a: int'(vbits[0 +: VB]), f: int'(vbits[VB +: VB]),
                    s: int'(vbits[2*VB +: VB]), b: int'(vbits[3*VB +: VB])};
            c.pol = cfg_pol;
            if (is_bad(c)) e_err = 1;
            else begin
                m_pend = 1;
                m_pcfg = c;
            end
        end
        if (do_apply) begin
            m_live = m_pcfg;
            m_pend = 0;
        end
        m_h++;
        if (m_h == ht) begin
            m_h = 0;
            m_v++;
            if (m_v == vt) m_v = 0;
        end
        e_rdy = !m_pend;
    endtask

    always @(posedge clk or negedge reset_low) begin
        if (!reset_low) m_reset();
        else m_step();
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (chk_en)
            check_eq("cycle", obs, pack(e_act, e_hs, e_vs, e_hst, e_vst, e_rdy, e_app, e_err,
                                        e_x, e_y));
    end

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic offer(input cfg_t c);
        cfg_h = {HB'(c.h.b), HB'(c.h.s), HB'(c.h.f), HB'(c.h.a)};
        cfg_v = {VB'(c.v.b), VB'(c.v.s), VB'(c.v.f), VB'(c.v.a)};
        cfg_pol = c.pol;
        cfg_valid = 1;
        tick(1);
        cfg_valid = 0;
    endtask

    task automatic wait_vstart(input string tag);
        bit seen = 0;
        for (int i = 0; i < TIMEOUT && !seen; i++) begin
            @(negedge clk);
            if (v_start) seen = 1;
        end
        check_eq(tag, 32'(seen), 32'd1);
    endtask

    task automatic frame_period(input string tag, input int expv);
        int t0;
        wait_vstart({tag, "_wait"});
        t0 = cyc;
        wait_vstart({tag, "_wait"});
        check_eq(tag, 32'(cyc - t0), 32'(expv));
    endtask

    task automatic sync_width(input string tag, input bit level, input int expv);
        int n = 0;
        int guard = 0;
        while (h_sync == level && guard < TIMEOUT) begin @(negedge clk); guard++; end
        while (h_sync != level && guard < TIMEOUT) begin @(negedge clk); guard++; end
        while (h_sync == level && guard < TIMEOUT) begin @(negedge clk); n++; guard++; end
        check_eq(tag, 32'(n), 32'(expv));
    endtask

    task automatic active_width(input string tag, input int expv);
        int n = 0;
        int guard = 0;
        while (!h_start && guard < TIMEOUT) begin @(negedge clk); guard++; end
        while (active && guard < TIMEOUT) begin @(negedge clk); n++; guard++; end
        check_eq(tag, 32'(n), 32'(expv));
    endtask

    task automatic wait_applied(input string tag);
        bit seen = 0;
        for (int i = 0; i < TIMEOUT && !seen; i++) begin
            @(negedge clk);
            if (cfg_applied) seen = 1;
        end
        check_eq(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_ready(input string tag);
        int i = 0;
        while (!cfg_ready && i < TIMEOUT) begin tick(1); i++; end
        check_eq(tag, 32'(cfg_ready), 32'd1);
    endtask

    task automatic wait_last_pixel();
        int i = 0;
        while (!(m_h == tot(m_live.h) - 1 && m_v == tot(m_live.v) - 1) && i < TIMEOUT) begin
            tick(1);
            i++;
        end
    endtask

    function automatic cfg_t rand_cfg();
        cfg_t c;
        c.h = '{a: int'($urandom_range(15, 1)), f: int'($urandom_range(6, 0)),
                s: int'($urandom_range(6, 1)), b: int'($urandom_range(6, 0))};
        c.v = '{a: int'($urandom_range(8, 1)), f: int'($urandom_range(3, 0)),
                s: int'($urandom_range(3, 1)), b: int'($urandom_range(3, 0))};
        c.pol = 2'($urandom_range(3, 0));
        if ($urandom_range(4, 0) == 0) c.h.a = 0;
        if ($urandom_range(6, 0) == 0) c.v.s = 0;
        return c;
    endfunction

    // ---------------- main sequence ----------------
    localparam logic [31:0] RST_VEC = {10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                       8'd0, 6'd0};

    initial begin
        cfg_t ca, cb, cbad;
        reset_low = 0;
        cfg_valid = 0;
        cfg_h = '0;
        cfg_v = '0;
        cfg_pol = 2'b00;
        m_reset();
        #1;
        check_eq("reset_vals", obs, RST_VEC);
        chk_en = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_low = 1;

        // Defaults: line 32, frame 32*19, sync 4 high, 20 active pixels.
        frame_period("frame_def", 32 * 19);
        sync_width("hsync_def", 1'b1, 4);
        active_width("active_def", 20);

        // Mid-frame reconfiguration, then a second offer while pending.
        tick(37);
        ca.h = '{a: 12, f: 2, s: 3, b: 4};
        ca.v = '{a: 6, f: 1, s: 2, b: 2};
        ca.pol = 2'b00;
        offer(ca);
        check_eq("ready_fall", 32'(cfg_ready), 32'd0);
        cb.h = '{a: 9, f: 1, s: 1, b: 1};
        cb.v = '{a: 3, f: 1, s: 1, b: 1};
        cb.pol = 2'b11;
        tick(3);
        offer(cb);
        check_eq("no_err_pending", 32'(cfg_error), 32'd0);
        wait_applied("applied_a");
        frame_period("frame_a", 21 * 11);
        sync_width("hsync_a", 1'b0, 3);
        active_width("active_a", 12);

        // Rejections: zero active, and HT one past the counter range.
        @(posedge clk); #1;
        cbad = ca;
        cbad.h.a = 0;
        offer(cbad);
        check_eq("err_zero_active", 32'(cfg_error), 32'd1);
        check_eq("ready_after_err", 32'(cfg_ready), 32'd1);
        cbad.h = '{a: 200, f: 20, s: 20, b: 17};
        offer(cbad);
        check_eq("err_ht_257", 32'(cfg_error), 32'd1);

        // HT exactly 2^H_BITS is legal.
        cbad.h.b = 16;
        cbad.v = '{a: 4, f: 1, s: 1, b: 1};
        cbad.pol = 2'b01;
        offer(cbad);
        check_eq("accept_ht_256", 32'(cfg_ready), 32'd0);
        wait_applied("applied_256");
        frame_period("frame_256", 256 * 7);

        // Random sets, half offered exactly on the frame's last pixel.
        @(posedge clk); #1;
        for (int it = 0; it < 8; it++) begin
            cfg_t cr;
            cr = rand_cfg();
            if (it % 2 == 0) wait_last_pixel();
            else tick(int'($urandom_range(60, 0)));
            offer(cr);
            wait_ready("ready_wait");
            tick(int'($urandom_range(40, 0)));
        end

        // Reset mid-line with a set pending.
        ca.h = '{a: 7, f: 1, s: 2, b: 1};
        offer(ca);
        tick(5);
        @(posedge clk);
        #3;
        reset_low = 0;
        #1;
        check_eq("async_reset", obs, RST_VEC);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_low = 1;
        frame_period("frame_after_reset", 32 * 19);
        active_width("active_after_reset", 20);

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
